// File: rtl/bnn_pkg.sv
// Shared constants and types for the MNIST BNN pipeline.
package bnn_pkg;

   // Top-level sequencer state encodings
   localparam logic [2:0] S_IDLE   = 3'b000;
   localparam logic [2:0] S_LOAD   = 3'b001;
   localparam logic [2:0] S_LAYER1 = 3'b010;

   // Geometry
   localparam int IMG_W = 28;
   localparam int K     = 3;
   localparam int L1_CH = 8;
   localparam int P1_W  = 14;

   localparam int NTAP     = K * K;
   localparam int IMG_BITS = IMG_W * IMG_W;
   localparam int W1_BITS  = K * K * L1_CH;
   localparam int L1_BITS  = P1_W * P1_W * L1_CH;

   typedef logic [3:0] popcnt_t;

   typedef enum logic [1:0] {
      L1_IDLE = 2'd0,
      L1_RUN  = 2'd1,
      L1_DONE = 2'd2
   } l1_fsm_e;

endpackage

// File: rtl/bnn_conv3x3_unit.sv
// One binary 3x3 convolution tap set: XNOR-popcount over the valid taps.
// Masked taps (outside the image) contribute nothing rather than an XNOR.
module bnn_conv3x3_unit
   import bnn_pkg::*;
(
   input  logic [NTAP-1:0] pix_i,
   input  logic [NTAP-1:0] valid_i,
   input  logic [NTAP-1:0] wgt_i,
   output popcnt_t         popcnt_o
);

   // Sum of XNOR matches over valid taps
   always_comb begin
      popcnt_o = '0;
      for (int t = 0; t < NTAP; t++) begin
         popcnt_o = popcnt_o + popcnt_t'(valid_i[t] & ~(pix_i[t] ^ wgt_i[t]));
      end
   end

endmodule

// File: rtl/bnn_layer1_conv.sv
// Layer-1 engine: 8 parallel binary 3x3 'same' convolutions, threshold
// activation and 2x2 max-pool, producing the 14x14x8 pooled map.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   L1_IDLE | waiting for S_LAYER1; counters held at zero
//   L1_RUN  | one conv position per cycle, pooled pixel written every 4
//   L1_DONE | l1_out complete; l1_done held until sequencer returns idle
//
// The scan order walks each 2x2 pool window (sub) before stepping pc/pr,
// so the pool accumulator only ever needs 8 bits.
module bnn_layer1_conv
   import bnn_pkg::*;
#(
   parameter int THRESH = 5
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          state,
   input  logic [IMG_BITS-1:0] pixels,
   input  logic [W1_BITS-1:0]  weights1,
   output logic [L1_BITS-1:0]  l1_out,
   output logic                l1_done
);

   localparam logic [4:0] THR    = 5'(THRESH);
   localparam logic [3:0] P_LAST = 4'(P1_W - 1);

   l1_fsm_e             fsm_q, fsm_d;
   logic [3:0]          pr_q, pr_d;
   logic [3:0]          pc_q, pc_d;
   logic [1:0]          sub_q, sub_d;
   logic [L1_CH-1:0]    acc_q, acc_d;
   logic [L1_BITS-1:0]  l1_out_q, l1_out_d;
   logic                l1_done_q, l1_done_d;

   logic [4:0]          conv_r, conv_c;
   logic [NTAP-1:0]     win_pix, win_vld;
   int                  win_rr, win_cc;
   logic [9:0]          win_idx;
   popcnt_t             popcnt [L1_CH];
   logic [L1_CH-1:0]    act;
   logic [10:0]         wr_base;
   logic                last_pos;

   assign conv_r   = {pr_q, sub_q[1]};
   assign conv_c   = {pc_q, sub_q[0]};
   assign last_pos = (pr_q == P_LAST) && (pc_q == P_LAST) && (sub_q == 2'd3);
   assign wr_base  = ({7'd0, pr_q} * 11'(P1_W) + {7'd0, pc_q}) * 11'(L1_CH);

   // Gather the 3x3 window around (conv_r, conv_c) with an in-image mask
   always_comb begin
      win_pix = '0;
      win_vld = '0;
      win_rr  = 0;
      win_cc  = 0;
      win_idx = '0;
      for (int kr = 0; kr < K; kr++) begin
         for (int kc = 0; kc < K; kc++) begin
            win_rr = int'(conv_r) + kr - 1;
            win_cc = int'(conv_c) + kc - 1;
            if (win_rr >= 0 && win_rr < IMG_W && win_cc >= 0 && win_cc < IMG_W) begin
               win_idx              = 10'(win_rr * IMG_W + win_cc);
               win_vld[kr * K + kc] = 1'b1;
               win_pix[kr * K + kc] = pixels[win_idx];
            end
         end
      end
   end

   for (genvar f = 0; f < L1_CH; f++) begin : g_filt
      logic [NTAP-1:0] wgt;
      // Kernel layout interleaves filters: tap t of filter f sits at t*L1_CH+f
      for (genvar t = 0; t < NTAP; t++) begin : g_tap
         assign wgt[t] = weights1[t * L1_CH + f];
      end

      bnn_conv3x3_unit u_conv (
         .pix_i    (win_pix),
         .valid_i  (win_vld),
         .wgt_i    (wgt),
         .popcnt_o (popcnt[f])
      );

      assign act[f] = ({1'b0, popcnt[f]} >= THR);
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q <= L1_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // FSM next state; abort from RUN takes priority over completion
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         L1_IDLE: if (state == S_LAYER1 && !l1_done_q) fsm_d = L1_RUN;
         L1_RUN: begin
            if (state != S_LAYER1) fsm_d = L1_IDLE;
            else if (last_pos)     fsm_d = L1_DONE;
         end
         L1_DONE: if (state == S_IDLE) fsm_d = L1_IDLE;
         default: fsm_d = L1_IDLE;
      endcase
   end

   // FSM outputs: counters, pool accumulator, pooled map and done flag
   always_comb begin
      pr_d      = pr_q;
      pc_d      = pc_q;
      sub_d     = sub_q;
      acc_d     = acc_q;
      l1_out_d  = l1_out_q;
      l1_done_d = (fsm_q == L1_DONE) && (state != S_IDLE);
      case (fsm_q)
         L1_IDLE: begin
            pr_d  = '0;
            pc_d  = '0;
            sub_d = '0;
            acc_d = '0;
         end
         L1_RUN: begin
            if (state != S_LAYER1) begin
               pr_d  = '0;
               pc_d  = '0;
               sub_d = '0;
               acc_d = '0;
            end else begin
               acc_d = (sub_q == 2'd0) ? act : (acc_q | act);
               sub_d = sub_q + 2'd1;
               if (sub_q == 2'd3) begin
                  l1_out_d[wr_base +: L1_CH] = acc_q | act;
                  acc_d = '0;
                  if (pc_q == P_LAST) begin
                     pc_d = '0;
                     pr_d = (pr_q == P_LAST) ? 4'd0 : pr_q + 4'd1;
                  end else begin
                     pc_d = pc_q + 4'd1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pr_q      <= '0;
         pc_q      <= '0;
         sub_q     <= '0;
         acc_q     <= '0;
         l1_out_q  <= '0;
         l1_done_q <= 1'b0;
      end else begin
         pr_q      <= pr_d;
         pc_q      <= pc_d;
         sub_q     <= sub_d;
         acc_q     <= acc_d;
         l1_out_q  <= l1_out_d;
         l1_done_q <= l1_done_d;
      end
   end

   assign l1_out  = l1_out_q;
   assign l1_done = l1_done_q;

endmodule

// File: tb/tb_bnn_layer1_conv.sv
// Directed bench for bnn_layer1_conv. Three instances share the stimulus
// and differ only in THRESH (5, 1, 10).
module tb_bnn_layer1_conv;
   import bnn_pkg::*;

   localparam int ROW_BITS = P1_W * L1_CH;

   logic                clk = 1'b0;
   logic                reset;
   logic [2:0]          state;
   logic [IMG_BITS-1:0] pixels;
   logic [W1_BITS-1:0]  weights1;

   logic [L1_BITS-1:0]  l1_out_t5, l1_out_t1, l1_out_t10;
   logic                l1_done_t5, l1_done_t1, l1_done_t10;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bnn_layer1_conv #(.THRESH(5)) u_dut_t5 (
      .clk(clk), .reset(reset), .state(state), .pixels(pixels),
      .weights1(weights1), .l1_out(l1_out_t5), .l1_done(l1_done_t5)
   );

   bnn_layer1_conv #(.THRESH(1)) u_dut_t1 (
      .clk(clk), .reset(reset), .state(state), .pixels(pixels),
      .weights1(weights1), .l1_out(l1_out_t1), .l1_done(l1_done_t1)
   );

   bnn_layer1_conv #(.THRESH(10)) u_dut_t10 (
      .clk(clk), .reset(reset), .state(state), .pixels(pixels),
      .weights1(weights1), .l1_out(l1_out_t10), .l1_done(l1_done_t10)
   );

   task automatic chk(input string tag, input logic [ROW_BITS-1:0] got,
                      input logic [ROW_BITS-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_map(input string tag, input logic [L1_BITS-1:0] got,
                          input logic [L1_BITS-1:0] exp);
      for (int r = 0; r < P1_W; r++) begin
         chk($sformatf("%s_row%0d", tag, r), got[r * ROW_BITS +: ROW_BITS],
             exp[r * ROW_BITS +: ROW_BITS]);
      end
   endtask

   // Start from IDLE and count edges from the IDLE->RUN edge until l1_done
   task automatic run_layer(input string tag);
      int n = 0;
      @(negedge clk);
      state = S_LAYER1;
      @(posedge clk);
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!l1_done_t5 && n < 1000);
      chk($sformatf("%s_latency", tag), ROW_BITS'(n), ROW_BITS'(785));
   endtask

   task automatic return_idle(input string tag);
      logic [L1_BITS-1:0] snap;
      snap = l1_out_t5;
      @(negedge clk);
      state = S_IDLE;
      @(negedge clk);
      chk($sformatf("%s_done_clr", tag), ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      chk_map($sformatf("%s_kept", tag), l1_out_t5, snap);
   endtask

   initial begin
      logic [L1_BITS-1:0] exp_map;
      logic               dropped;

      reset    = 1'b1;
      state    = S_IDLE;
      pixels   = '0;
      weights1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      chk_map("rst_out", l1_out_t5, '0);
      reset = 1'b0;

      // IDLE must not start on anything but S_LAYER1
      state = S_LOAD;
      repeat (10) @(negedge clk);
      chk("idle_load_done", ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      state = S_IDLE;

      // All ones: THRESH=5 gives all 1, THRESH=10 gives all 0
      pixels   = '1;
      weights1 = '1;
      run_layer("t1");
      chk_map("t1_out", l1_out_t5, '1);
      chk_map("t1_thr1", l1_out_t1, '1);
      chk_map("t6_out", l1_out_t10, '0);
      chk("t6_done", ROW_BITS'(l1_done_t10), ROW_BITS'(1));

      // Holding S_LAYER1 in DONE must not restart
      dropped = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (!l1_done_t5 || !l1_done_t10) dropped = 1'b1;
      end
      chk("t6_no_restart", ROW_BITS'(dropped), ROW_BITS'(0));
      chk_map("t6_hold_out", l1_out_t10, '0);
      return_idle("t6");

      // All pixels 0; filter 0 weights 1 -> ch0 off, others on
      pixels   = '0;
      weights1 = '0;
      for (int t = 0; t < NTAP; t++) weights1[t * L1_CH] = 1'b1;
      for (int p = 0; p < P1_W * P1_W; p++) exp_map[p * L1_CH +: L1_CH] = 8'hFE;
      run_layer("t2");
      chk_map("t2_out", l1_out_t5, exp_map);
      return_idle("t2");

      // Single pixel (5,5); filter 3 weights 1; THRESH=1.
      // Conv rows/cols 4..6 see it -> pooled (pr,pc) in {2,3}x{2,3}:
      // bits (2*14+2)*8+3=243, 251, (3*14+2)*8+3=355, 363.
      pixels   = '0;
      pixels[5 * IMG_W + 5] = 1'b1;
      weights1 = '0;
      for (int t = 0; t < NTAP; t++) weights1[t * L1_CH + 3] = 1'b1;
      for (int p = 0; p < P1_W * P1_W; p++) exp_map[p * L1_CH +: L1_CH] = 8'hF7;
      exp_map[243] = 1'b1;
      exp_map[251] = 1'b1;
      exp_map[355] = 1'b1;
      exp_map[363] = 1'b1;
      run_layer("t3");
      chk_map("t3_out", l1_out_t1, exp_map);
      chk("t3_bit243", ROW_BITS'(l1_out_t1[243]), ROW_BITS'(1));
      chk("t3_bit235", ROW_BITS'(l1_out_t1[235]), ROW_BITS'(0));
      return_idle("t3");

      // Abort after 100 RUN cycles: 25 pooled pixels (bits 0..199) written
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      pixels   = '1;
      weights1 = '1;
      @(negedge clk);
      state = S_LAYER1;
      @(posedge clk);
      repeat (100) @(posedge clk);
      @(negedge clk);
      state = S_LOAD;
      repeat (5) @(negedge clk);
      chk("t4_abort_done", ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      exp_map = '0;
      for (int i = 0; i < 200; i++) exp_map[i] = 1'b1;
      chk_map("t4_partial", l1_out_t5, exp_map);
      run_layer("t4");
      chk_map("t4_out", l1_out_t5, '1);
      return_idle("t4");

      // Reset asserted asynchronously in the middle of a run
      @(negedge clk);
      state = S_LAYER1;
      @(posedge clk);
      repeat (400) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_done", ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      chk_map("t5_rst_out", l1_out_t5, '0);
      @(negedge clk);
      state = S_IDLE;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("t5_idle_done", ROW_BITS'(l1_done_t5), ROW_BITS'(0));
      chk_map("t5_idle_out", l1_out_t5, '0);
      run_layer("t5");
      chk_map("t5_out", l1_out_t5, '1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
